// File: rtl/frame_forward_engine.sv
// frame_forward_engine
//   Pops one frame descriptor, reads the frame from the ingress byte FIFO,
//   captures DMAC/SMAC/type, runs a lookup and forwards the frame to the
//   fabric. Each forwarded frame is preceded by a 2-byte length header and is
//   zero-padded to MIN_LEN. Runt frames, lookup misses, timeouts and frames
//   with no live egress port are discarded and counted.
// Ports
//   clk, rstn                  clock, async active-low reset
//   ptr_sfifo_rd/_dout/_empty  descriptor FIFO (length in [LEN_W-1:0])
//   sfifo_rd/sfifo_dout        frame byte FIFO, data valid the cycle after rd
//   se_req/se_dmac/se_smac/se_hash, se_ack/se_nak/se_result  lookup handshake
//   link, bp                   per-port link-up and egress backpressure
//   sof/dv/data/o_portmap      egress byte stream and port map
//   drop_cnt                   saturating discarded-frame count
module frame_forward_engine #(
  parameter int unsigned NPORTS     = 4,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned SE_TIMEOUT = 255,
  parameter int unsigned LEN_W      = 11
) (
  input  logic              clk,
  input  logic              rstn,
  output logic              ptr_sfifo_rd,
  input  logic [15:0]       ptr_sfifo_dout,
  input  logic              ptr_sfifo_empty,
  output logic              sfifo_rd,
  input  logic [7:0]        sfifo_dout,
  output logic              se_req,
  output logic [47:0]       se_dmac,
  output logic [47:0]       se_smac,
  output logic [11:0]       se_hash,
  input  logic              se_ack,
  input  logic              se_nak,
  input  logic [15:0]       se_result,
  input  logic [NPORTS-1:0] link,
  input  logic [NPORTS-1:0] bp,
  output logic              sof,
  output logic              dv,
  output logic [7:0]        data,
  output logic [NPORTS-1:0] o_portmap,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned KW = 13;

  typedef enum logic [2:0] {IDLE, PTR, HDR, SEARCH, BPWAIT, TX, PAD, DROP} state_t;

  state_t            state_q, state_d;
  logic              ptr_rd_q, ptr_rd_d;
  logic              sfifo_rd_q, sfifo_rd_d;
  logic              rd_dly_q;
  logic              se_req_q, se_req_d;
  logic              sof_q, sof_d;
  logic              dv_q, dv_d;
  logic [7:0]        data_q, data_d;
  logic [NPORTS-1:0] opm_q, opm_d;
  logic [NPORTS-1:0] pm_q, pm_d;
  logic [15:0]       drop_q, drop_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [KW-1:0]     pop_q, pop_d;   // sfifo pops committed for this descriptor
  logic [KW-1:0]     k_q, k_d;       // capture index in HDR, output byte index in TX/PAD
  logic [15:0]       to_q, to_d;
  logic [7:0]        hdr_q [14];
  logic [7:0]        hdr_d [14];

  logic [KW-1:0]     len_k, e_k, k_m2;
  logic [11:0]       e_len;
  logic [NPORTS-1:0] pm_hit, go_pm;
  logic              to_last, go_tx, drop_go;
  logic              unused_bits;

  assign len_k   = KW'(len_q);
  assign e_k     = (len_k < KW'(MIN_LEN)) ? KW'(MIN_LEN) : len_k;
  assign e_len   = e_k[11:0];
  assign k_m2    = k_q - KW'(2);
  assign pm_hit  = se_result[NPORTS-1:0] & link;
  assign to_last = (SE_TIMEOUT != 0) && (to_q == 16'(SE_TIMEOUT - 1));
  assign unused_bits = ^{ptr_sfifo_dout, se_result};

  always_comb begin
    state_d    = state_q;
    ptr_rd_d   = 1'b0;
    sfifo_rd_d = 1'b0;
    se_req_d   = 1'b0;
    sof_d      = 1'b0;
    dv_d       = 1'b0;
    data_d     = '0;
    opm_d      = '0;
    pm_d       = pm_q;
    drop_d     = drop_q;
    len_d      = len_q;
    pop_d      = pop_q;
    k_d        = k_q;
    to_d       = to_q;
    hdr_d      = hdr_q;
    go_tx      = 1'b0;
    go_pm      = '0;
    drop_go    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!ptr_sfifo_empty) begin
          ptr_rd_d = 1'b1;
          state_d  = PTR;
        end
      end
      PTR: begin
        // first PTR cycle is the pop itself; the descriptor is valid on the second
        if (!ptr_rd_q) begin
          len_d = ptr_sfifo_dout[LEN_W-1:0];
          pop_d = '0;
          k_d   = '0;
          if (ptr_sfifo_dout[LEN_W-1:0] < LEN_W'(14)) begin
            drop_go = 1'b1;
          end else begin
            sfifo_rd_d = 1'b1;
            pop_d      = KW'(1);
            state_d    = HDR;
          end
        end
      end
      HDR: begin
        if (pop_q < KW'(14)) begin
          sfifo_rd_d = 1'b1;
          pop_d      = pop_q + KW'(1);
        end
        if (rd_dly_q) begin
          hdr_d[k_q[3:0]] = sfifo_dout;
          k_d             = k_q + KW'(1);
          if (k_q == KW'(13)) begin
            state_d  = SEARCH;
            se_req_d = 1'b1;
            to_d     = '0;
          end
        end
      end
      SEARCH: begin
        to_d = to_q + 16'd1;
        // nak beats a simultaneous ack; an ack on the final timeout cycle beats the timeout
        if (se_nak) begin
          drop_go = 1'b1;
        end else if (se_ack) begin
          pm_d = pm_hit;
          if (pm_hit == '0) begin
            drop_go = 1'b1;
          end else if ((bp & pm_hit) == '0) begin
            go_tx = 1'b1;
            go_pm = pm_hit;
          end else begin
            state_d = BPWAIT;
          end
        end else if (to_last) begin
          drop_go = 1'b1;
        end else begin
          se_req_d = 1'b1;
        end
      end
      BPWAIT: begin
        if ((bp & pm_q) == '0) begin
          go_tx = 1'b1;
          go_pm = pm_q;
        end
      end
      TX, PAD: begin
        dv_d  = 1'b1;
        opm_d = opm_q;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(1))          data_d = e_len[7:0];
        else if (k_q < KW'(16))     data_d = hdr_q[k_m2[3:0]];
        else if (k_q < len_k + KW'(2)) data_d = sfifo_dout;
        else                        data_d = 8'h00;
        // body pops lead their output slot by two cycles so the first body
        // byte lands right after the replayed type LSB
        if ((k_q >= KW'(14)) && (pop_q < len_k)) begin
          sfifo_rd_d = 1'b1;
          pop_d      = pop_q + KW'(1);
        end
        if (k_q == e_k + KW'(1))                  state_d = IDLE;
        else if (k_q + KW'(1) >= len_k + KW'(2))  state_d = PAD;
      end
      DROP: begin
        if (pop_q < len_k) begin
          sfifo_rd_d = 1'b1;
          pop_d      = pop_q + KW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop_go) begin
      state_d  = DROP;
      se_req_d = 1'b0;
      if (drop_q != '1) drop_d = drop_q + 16'd1;
    end
    if (go_tx) begin
      state_d = TX;
      sof_d   = 1'b1;
      dv_d    = 1'b1;
      data_d  = {4'h0, e_len[11:8]};
      k_d     = KW'(1);
      opm_d   = go_pm;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_rd_q   <= 1'b0;
      sfifo_rd_q <= 1'b0;
      rd_dly_q   <= 1'b0;
      se_req_q   <= 1'b0;
      sof_q      <= 1'b0;
      dv_q       <= 1'b0;
      data_q     <= '0;
      opm_q      <= '0;
      pm_q       <= '0;
      drop_q     <= '0;
      len_q      <= '0;
      pop_q      <= '0;
      k_q        <= '0;
      to_q       <= '0;
      for (int unsigned i = 0; i < 14; i++) hdr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_rd_q   <= ptr_rd_d;
      sfifo_rd_q <= sfifo_rd_d;
      rd_dly_q   <= sfifo_rd_q;
      se_req_q   <= se_req_d;
      sof_q      <= sof_d;
      dv_q       <= dv_d;
      data_q     <= data_d;
      opm_q      <= opm_d;
      pm_q       <= pm_d;
      drop_q     <= drop_d;
      len_q      <= len_d;
      pop_q      <= pop_d;
      k_q        <= k_d;
      to_q       <= to_d;
      hdr_q      <= hdr_d;
    end
  end

  assign ptr_sfifo_rd = ptr_rd_q;
  assign sfifo_rd     = sfifo_rd_q;
  assign se_req       = se_req_q;
  assign se_dmac      = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
  assign se_smac      = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
  assign se_hash      = {se_smac[4:0], se_dmac[6:0]};
  assign sof          = sof_q;
  assign dv           = dv_q;
  assign data         = data_q;
  assign o_portmap    = opm_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_frame_forward_engine.sv
module tb_frame_forward_engine;
  localparam int unsigned NP   = 8;
  localparam int unsigned MINL = 60;
  localparam int unsigned TO   = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          ptr_sfifo_rd;
  logic [15:0]   ptr_sfifo_dout = '0;
  logic          ptr_sfifo_empty = 1'b1;
  logic          sfifo_rd;
  logic [7:0]    sfifo_dout = '0;
  logic          se_req;
  logic [47:0]   se_dmac, se_smac;
  logic [11:0]   se_hash;
  logic          se_ack = 1'b0, se_nak = 1'b0;
  logic [15:0]   se_result = '0;
  logic [NP-1:0] link = '0, bp = '0;
  logic          sof, dv;
  logic [7:0]    data;
  logic [NP-1:0] o_portmap;
  logic [15:0]   drop_cnt;

  frame_forward_engine #(.NPORTS(NP), .MIN_LEN(MINL), .SE_TIMEOUT(TO), .LEN_W(11)) dut (
    .clk(clk), .rstn(rstn),
    .ptr_sfifo_rd(ptr_sfifo_rd), .ptr_sfifo_dout(ptr_sfifo_dout), .ptr_sfifo_empty(ptr_sfifo_empty),
    .sfifo_rd(sfifo_rd), .sfifo_dout(sfifo_dout),
    .se_req(se_req), .se_dmac(se_dmac), .se_smac(se_smac), .se_hash(se_hash),
    .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .link(link), .bp(bp),
    .sof(sof), .dv(dv), .data(data), .o_portmap(o_portmap), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream FIFO models
  logic [15:0] dq[$];
  logic [7:0]  bq[$];
  int unsigned pops = 0;
  int unsigned underflow = 0;
  always @(posedge clk) begin
    if (ptr_sfifo_rd && dq.size() > 0) begin
      ptr_sfifo_dout <= dq.pop_front();
      if (dq.size() == 0) ptr_sfifo_empty <= 1'b1;
    end
    if (sfifo_rd) begin
      pops <= pops + 1;
      if (bq.size() > 0) sfifo_dout <= bq.pop_front();
      else underflow <= underflow + 1;
    end
  end

  // lookup responder
  int           kind = 0;          // 0 ack, 1 nak, 2 ack+nak, 3 silent
  int unsigned  dly = 1;
  int unsigned  exp_req_len = 1;
  logic [15:0]  res_cfg = '0;
  logic [47:0]  exp_dmac, exp_smac;
  int unsigned  rcnt = 0;
  int unsigned  eps = 0;
  int unsigned  ack_cyc = 0;
  always @(negedge clk) begin
    se_ack = 1'b0;
    se_nak = 1'b0;
    se_result = 16'($urandom);
    if (!rstn) begin
      rcnt = 0;
    end else if (se_req) begin
      rcnt++;
      if (rcnt == 1) begin
        eps++;
        chk("se_dmac", se_dmac, exp_dmac);
        chk("se_smac", se_smac, exp_smac);
        chk("se_hash", se_hash, {exp_smac[4:0], exp_dmac[6:0]});
      end
      if (rcnt == dly && kind != 3) begin
        se_ack = (kind == 0 || kind == 2);
        se_nak = (kind == 1 || kind == 2);
        se_result = res_cfg;
        ack_cyc = cyc;
      end
    end else if (rcnt > 0) begin
      chk("se_req_len", rcnt, exp_req_len);
      rcnt = 0;
    end
  end

  // scoreboard monitor
  logic [7:0]    exp_bytes[$];
  int unsigned   exp_len[$];
  logic [NP-1:0] exp_pm[$];
  logic [7:0]    cur[$];
  bit            in_frame = 1'b0;
  bit            pm_changed = 1'b0;
  bit            bp_mode = 1'b0;
  logic [NP-1:0] cur_pm;
  int unsigned   frames_done = 0;
  int unsigned   m_n, m_bad;
  logic [NP-1:0] m_epm;
  logic [7:0]    m_b;
  always @(negedge clk) begin
    if (!rstn) begin
      in_frame = 1'b0;
      cur.delete();
    end else if (dv) begin
      if (sof) begin
        if (in_frame) chk("sof_mid_frame", 1, 0);
        in_frame = 1'b1;
        cur.delete();
        cur_pm = o_portmap;
        pm_changed = 1'b0;
        if (!bp_mode) chk("ack_to_sof", cyc, ack_cyc + 1);
      end else if (!in_frame) begin
        chk("dv_without_sof", 1, 0);
        in_frame = 1'b1;
        cur_pm = o_portmap;
        pm_changed = 1'b0;
      end
      if (o_portmap !== cur_pm) pm_changed = 1'b1;
      cur.push_back(data);
    end else if (in_frame) begin
      in_frame = 1'b0;
      frames_done++;
      if (exp_len.size() == 0) begin
        chk("unexpected_frame", cur.size(), 0);
      end else begin
        m_n = exp_len.pop_front();
        m_epm = exp_pm.pop_front();
        m_bad = 0;
        for (int unsigned i = 0; i < m_n; i++) begin
          m_b = exp_bytes.pop_front();
          if (i >= cur.size() || cur[i] !== m_b) m_bad++;
        end
        chk("frame_len", cur.size(), m_n);
        chk("frame_bytes_bad", m_bad, 0);
        chk("portmap", {pm_changed, cur_pm}, {1'b0, m_epm});
      end
    end
  end

  // stimulus
  int unsigned exp_drop = 0;
  int unsigned p0, f0, e0;

  task automatic stage_frame(input int unsigned L, input int kd, input int unsigned d,
                             input logic [15:0] res, input logic [NP-1:0] lnk,
                             input bit bph, output bit fwd);
    logic [7:0]    fb[$];
    logic [NP-1:0] pm;
    int unsigned   e;
    pm  = res[NP-1:0] & lnk;
    fwd = (L >= 14) && (kd == 0) && (d <= TO) && (pm != '0);
    kind = kd; dly = d; res_cfg = res; link = lnk;
    bp = bph ? pm : '0;
    bp_mode = bph;
    exp_req_len = (kd != 3 && d <= TO) ? d : TO;
    for (int unsigned i = 0; i < L; i++) fb.push_back(8'($urandom));
    if (L >= 14) begin
      exp_dmac = '0; exp_smac = '0;
      for (int unsigned i = 0; i < 6; i++) begin
        exp_dmac = {exp_dmac[39:0], fb[i]};
        exp_smac = {exp_smac[39:0], fb[i+6]};
      end
    end
    if (fwd) begin
      e = (L < MINL) ? MINL : L;
      exp_len.push_back(e + 2);
      exp_pm.push_back(pm);
      exp_bytes.push_back(8'(e >> 8));
      exp_bytes.push_back(8'(e));
      for (int unsigned i = 0; i < e; i++) exp_bytes.push_back(i < L ? fb[i] : 8'h00);
    end else begin
      exp_drop++;
    end
    p0 = pops; f0 = frames_done; e0 = eps;
    foreach (fb[i]) bq.push_back(fb[i]);
    dq.push_back({5'($urandom), 11'(L)});
    ptr_sfifo_empty = 1'b0;
  endtask

  task automatic run_frame(input int unsigned L, input int kd, input int unsigned d,
                           input logic [15:0] res, input logic [NP-1:0] lnk, input bit bph);
    bit fwd, done, seen;
    int unsigned bad;
    @(negedge clk);
    stage_frame(L, kd, d, res, lnk, bph, fwd);
    if (bph) begin
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
        @(posedge clk);
        if (se_ack) seen = 1'b1;
      end
      chk("bp_ack_seen", seen, 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (dv) bad++;
      end
      chk("bp_hold_no_dv", bad, 0);
      bp = '0;
      @(negedge clk);
      chk("sof_after_bp", sof, 1);
    end
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if ((pops - p0 == L) && (!fwd || frames_done - f0 == 1)) done = 1'b1;
    end
    chk("frame_done_in_time", done, 1);
    repeat (4) @(negedge clk);
    chk("pops", pops - p0, L);
    chk("underflow", underflow, 0);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("se_episodes", eps - e0, (L >= 14) ? 1 : 0);
  endtask

  function automatic bit outs_nonzero();
    return |{ptr_sfifo_rd, sfifo_rd, se_req, se_dmac, se_smac, se_hash,
             sof, dv, data, o_portmap, drop_cnt};
  endfunction

  initial begin
    bit fwd, seen;
    int r;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_nonzero(), 0);
    rstn = 1'b1;

    // directed cases: L, kind, delay, result, link, bp hold
    run_frame(64,  0, 2, 16'h0002, 8'h0F, 0);
    run_frame(42,  0, 3, 16'h0002, 8'h0F, 0);
    run_frame(100, 1, 2, 16'h0002, 8'h0F, 0);
    run_frame(100, 0, 2, 16'h0001, 8'hFE, 0);
    run_frame(80,  3, 1, 16'h0002, 8'hFF, 0);
    run_frame(70,  0, TO, 16'h0003, 8'hFF, 0);
    run_frame(70,  2, 3, 16'h0003, 8'hFF, 0);
    run_frame(10,  0, 2, 16'h0002, 8'hFF, 0);
    run_frame(14,  0, 1, 16'h0010, 8'hFF, 0);
    run_frame(60,  0, 4, 16'h0020, 8'hFF, 0);
    run_frame(0,   0, 2, 16'h0002, 8'hFF, 0);
    run_frame(13,  0, 2, 16'h0002, 8'hFF, 0);
    run_frame(300, 0, 2, 16'hFF80, 8'hFF, 0);
    run_frame(64,  0, 3, 16'h0004, 8'hFF, 1);
    run_frame(61,  0, 5, 16'h0041, 8'hC1, 0);

    // randomized frames, biased toward hits
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 5));
      run_frame($urandom_range(0, 160), (r < 3) ? 0 : r - 2, $urandom_range(1, TO + 1),
                16'($urandom), NP'($urandom), 0);
    end

    // reset in the middle of transmission
    @(negedge clk);
    stage_frame(200, 0, 2, 16'h0008, 8'hFF, 0, fwd);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sof) seen = 1'b1;
    end
    chk("reset_test_sof", seen, 1);
    repeat (10) @(negedge clk);
    #1 rstn = 1'b0;
    #1 chk("reset_mid_tx_outputs", outs_nonzero(), 0);
    dq.delete(); bq.delete();
    exp_len.delete(); exp_pm.delete(); exp_bytes.delete();
    ptr_sfifo_empty = 1'b1;
    exp_drop = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    run_frame(50, 0, 2, 16'h0001, 8'hFF, 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
